// File: rtl/cosim_run_pkg.sv
// Shared types and finish codes for the co-simulation run sequencer.
// Finish codes are what the DPI layer reads back when finishValid rises.
package cosim_run_pkg;

  typedef enum logic [2:0] {
    RST   = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } run_state_e;

  localparam logic [7:0] FIN_RUNNING = 8'd0;
  localparam logic [7:0] FIN_PASS    = 8'd255;
  localparam logic [7:0] FIN_WDOG    = 8'd1;
  localparam logic [7:0] FIN_DUMPEND = 8'd2;
  localparam logic [7:0] FIN_EXTERR  = 8'd3;
  localparam logic [7:0] FIN_DRAIN   = 8'd4;

endpackage

// File: rtl/cosim_watchdog.sv
// Commit watchdog: counts cycles since the last kick while enabled.
// expired is combinational and tells the owner that this edge would reach the limit.
module cosim_watchdog (
  input  logic        clock,
  input  logic        resetN,
  input  logic        clr,
  input  logic        en,
  input  logic        kick,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (kick) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + 32'd1;
      end
    end
  end

  // A kick on the expiring edge rescues the run; limit 0 disables the check.
  assign expired = en && !kick && (limit != '0) && (count == limit - 32'd1);

endmodule

// File: rtl/cosim_run_sequencer.sv
// Run controller for the emulation testbench: DUT reset/init sequencing, cycle count,
// commit watchdog, waveform dump window and the pass/fail decision.
module cosim_run_sequencer
  import cosim_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned INIT_CYCLES  = 1,
  parameter int unsigned DRAIN_LIMIT  = 1024,
  parameter int unsigned CNT_W        = 64
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             commit,
  input  logic             idle,
  input  logic             doneReq,
  input  logic             errReq,
  input  logic [31:0]      maxInterval,
  input  logic [CNT_W-1:0] dumpStart,
  input  logic [CNT_W-1:0] dumpEnd,
  output logic             dutReset,
  output logic             initFlag,
  output logic             dumpEnable,
  output logic [CNT_W-1:0] cycle,
  output logic             finishValid,
  output logic [7:0]       finishCode,
  output run_state_e       dbg_state
);

  // finishValid/finishCode form a valid-only channel (no ready): once finishValid
  // rises it is sticky until resetN, and finishCode is stable whenever it is high.

  run_state_e       state, state_nxt;
  logic [7:0]       code_nxt;
  logic [CNT_W-1:0] cycle_nxt;
  logic [31:0]      phase_cnt, phase_nxt;
  logic             dump_hit, wd_expired, terminal, fin_nxt;

  cosim_watchdog u_wdog (
    .clock   (clock),
    .resetN  (resetN),
    .clr     (state == RST),
    .en      (state == RUN),
    .kick    (commit),
    .limit   (maxInterval),
    .expired (wd_expired)
  );

  // Every decision is taken against the cycle value this edge will publish,
  // so all registered outputs agree with the cycle they are shown alongside.
  always_comb begin
    terminal  = (state == PASS) || (state == FAIL);
    cycle_nxt = cycle;
    if (!terminal && (cycle != '1)) begin
      cycle_nxt = cycle + CNT_W'(1);
    end
    dump_hit  = (dumpEnd != '0) && (cycle_nxt == dumpEnd);
    state_nxt = state;
    code_nxt  = finishCode;
    phase_nxt = '0;

    unique case (state)
      RST: begin
        if (dump_hit) begin
          state_nxt = FAIL;
          code_nxt  = FIN_DUMPEND;
        end else if (cycle_nxt >= CNT_W'(RESET_CYCLES)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (errReq) begin
          state_nxt = FAIL;
          code_nxt  = FIN_EXTERR;
        end else if (dump_hit) begin
          state_nxt = FAIL;
          code_nxt  = FIN_DUMPEND;
        end else if (wd_expired) begin
          state_nxt = FAIL;
          code_nxt  = FIN_WDOG;
        end else if (doneReq) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        phase_nxt = phase_cnt + 32'd1;
        if (errReq) begin
          state_nxt = FAIL;
          code_nxt  = FIN_EXTERR;
        end else if (dump_hit) begin
          state_nxt = FAIL;
          code_nxt  = FIN_DUMPEND;
        end else if (idle) begin
          state_nxt = PASS;
          code_nxt  = FIN_PASS;
        end else if (phase_nxt == 32'(DRAIN_LIMIT)) begin
          state_nxt = FAIL;
          code_nxt  = FIN_DRAIN;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase

    fin_nxt = (state_nxt == PASS) || (state_nxt == FAIL);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= RST;
      cycle       <= '0;
      phase_cnt   <= '0;
      dutReset    <= 1'b1;
      initFlag    <= 1'b1;
      dumpEnable  <= 1'b0;
      finishValid <= 1'b0;
      finishCode  <= FIN_RUNNING;
    end else begin
      state       <= state_nxt;
      cycle       <= cycle_nxt;
      phase_cnt   <= phase_nxt;
      dutReset    <= (state_nxt == RST);
      initFlag    <= initFlag && (cycle_nxt < CNT_W'(INIT_CYCLES));
      dumpEnable  <= !fin_nxt && (dumpStart <= cycle_nxt) &&
                     ((dumpEnd == '0) || (cycle_nxt < dumpEnd));
      finishValid <= fin_nxt;
      finishCode  <= code_nxt;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_cosim_run_sequencer.sv
// Bench for cosim_run_sequencer: per-edge input plans, an event-time reference model
// that predicts the finishing edge and code, and per-cycle output checks.
module tb_cosim_run_sequencer;
  import cosim_run_pkg::*;

  localparam int RESET_CYCLES = 5;
  localparam int INIT_CYCLES  = 1;
  localparam int DRAIN_LIMIT  = 1024;
  localparam int CNT_W        = 64;
  localparam int MAXN         = 2048;
  localparam int INF          = 1 << 30;

  // clock/reset block
  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  logic             commit = 1'b0, idle = 1'b0, doneReq = 1'b0, errReq = 1'b0;
  logic [31:0]      maxInterval = '0;
  logic [CNT_W-1:0] dumpStart = '0, dumpEnd = '0;
  logic             dutReset, initFlag, dumpEnable, finishValid;
  logic [CNT_W-1:0] cycle;
  logic [7:0]       finishCode;
  run_state_e       dbg_state;

  cosim_run_sequencer dut (
    .clock(clock), .resetN(resetN), .commit(commit), .idle(idle),
    .doneReq(doneReq), .errReq(errReq), .maxInterval(maxInterval),
    .dumpStart(dumpStart), .dumpEnd(dumpEnd), .dutReset(dutReset),
    .initFlag(initFlag), .dumpEnable(dumpEnable), .cycle(cycle),
    .finishValid(finishValid), .finishCode(finishCode), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // input plan indexed by the edge number (1 = first edge after release) that samples it
  bit commit_v[MAXN], done_v[MAXN], idle_v[MAXN], err_v[MAXN];
  int         fin_n;
  logic [7:0] fin_code;

  task automatic chk(input string tag, input int n, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @edge %0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic plan_clear();
    for (int i = 0; i < MAXN; i++) begin
      commit_v[i] = 1'b0; done_v[i] = 1'b0; idle_v[i] = 1'b0; err_v[i] = 1'b0;
    end
    maxInterval = '0; dumpStart = '0; dumpEnd = '0;
  endtask

  // Reference model: find when each terminating event would first occur, then
  // take the earliest, breaking ties by err > dump_end > watchdog > pass > drain.
  task automatic predict();
    int t_err = INF, t_dump = INF, t_done = INF, t_wd = INF, t_pass = INF, t_drain = INF;
    int last, m, t[5];
    logic [7:0] c[5];
    m = int'(maxInterval);
    for (int n = RESET_CYCLES + 1; n < MAXN; n++) begin
      if (err_v[n] && t_err == INF) t_err = n;
      if (done_v[n] && t_done == INF) t_done = n;
    end
    if (dumpEnd != '0 && dumpEnd < 64'(MAXN)) t_dump = int'(dumpEnd);
    if (m != 0) begin
      last = RESET_CYCLES;
      for (int n = RESET_CYCLES + 1; n <= t_done && n < MAXN && t_wd == INF; n++) begin
        if (commit_v[n]) last = n;
        else if (n - last == m) t_wd = n;
      end
    end
    if (t_done != INF) begin
      t_drain = t_done + DRAIN_LIMIT;
      for (int n = t_done + 1; n < MAXN && t_pass == INF; n++)
        if (idle_v[n]) t_pass = n;
    end
    t[0] = t_err;  c[0] = FIN_EXTERR;
    t[1] = t_dump; c[1] = FIN_DUMPEND;
    t[2] = t_wd;   c[2] = FIN_WDOG;
    t[3] = t_pass; c[3] = FIN_PASS;
    t[4] = t_drain; c[4] = FIN_DRAIN;
    fin_n = INF; fin_code = FIN_RUNNING;
    for (int k = 0; k < 5; k++)
      if (t[k] < fin_n) begin fin_n = t[k]; fin_code = c[k]; end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ":rst_cycle"}, 0, cycle, '0);
    chk({tag, ":rst_initFlag"}, 0, 64'(initFlag), 64'd1);
    chk({tag, ":rst_dutReset"}, 0, 64'(dutReset), 64'd1);
    chk({tag, ":rst_dumpEnable"}, 0, 64'(dumpEnable), 64'd0);
    chk({tag, ":rst_finishValid"}, 0, 64'(finishValid), 64'd0);
    chk({tag, ":rst_finishCode"}, 0, 64'(finishCode), 64'd0);
  endtask

  task automatic check_outputs(input string tag, input int n);
    bit f;
    int nn;
    f  = (n >= fin_n);
    nn = f ? fin_n : n;
    chk({tag, ":cycle"}, n, cycle, 64'(nn));
    chk({tag, ":initFlag"}, n, 64'(initFlag), 64'(nn < INIT_CYCLES));
    chk({tag, ":dutReset"}, n, 64'(dutReset), 64'(!f && nn < RESET_CYCLES));
    chk({tag, ":dumpEnable"}, n, 64'(dumpEnable),
        64'(!f && dumpStart <= 64'(nn) && (dumpEnd == '0 || 64'(nn) < dumpEnd)));
    chk({tag, ":finishValid"}, n, 64'(finishValid), 64'(f));
    chk({tag, ":finishCode"}, n, 64'(finishCode), f ? 64'(fin_code) : 64'd0);
  endtask

  // driver: asynchronous reset mid-phase (no clock edge), then replay the plan edge by edge
  task automatic run_scenario(input string tag, input int edges);
    predict();
    resetN = 1'b0;
    commit = 1'b0; doneReq = 1'b0; idle = 1'b0; errReq = 1'b0;
    #2;
    check_reset(tag);
    resetN = 1'b1;
    for (int n = 1; n <= edges; n++) begin
      commit = commit_v[n]; doneReq = done_v[n]; idle = idle_v[n]; errReq = err_v[n];
      @(posedge clock);
      @(negedge clock);
      check_outputs(tag, n);
    end
  endtask

  initial begin
    int m, k, stop_at, edges;
    @(negedge clock);

    // dump window 10..19, then dump_end fail at 20
    plan_clear();
    dumpStart = 64'd10; dumpEnd = 64'd20;
    run_scenario("dump", 25);

    // watchdog: commits every 50, then silence -> fail 100 edges after last commit
    plan_clear();
    maxInterval = 32'd100;
    commit_v[55] = 1'b1; commit_v[105] = 1'b1; commit_v[155] = 1'b1;
    run_scenario("wdog", 260);

    // commit on the expiring edge keeps the run alive
    plan_clear();
    maxInterval = 32'd100;
    commit_v[55] = 1'b1; commit_v[155] = 1'b1;
    run_scenario("wdog_rescue", 260);

    // plain RUN with nothing happening; next scenario resets out of RUN
    plan_clear();
    run_scenario("run_idle", 30);

    // pass: doneReq from 201, idle from 211
    plan_clear();
    for (int n = 201; n < MAXN; n++) done_v[n] = 1'b1;
    for (int n = 211; n < MAXN; n++) idle_v[n] = 1'b1;
    run_scenario("pass", 225);

    // doneReq and idle together still go through DRAIN
    plan_clear();
    for (int n = 50; n < MAXN; n++) begin done_v[n] = 1'b1; idle_v[n] = 1'b1; end
    run_scenario("pass_same", 56);

    // drain timeout with idle held low
    plan_clear();
    for (int n = 20; n < MAXN; n++) done_v[n] = 1'b1;
    run_scenario("drain", 20 + DRAIN_LIMIT + 4);

    // errReq pulse during DRAIN
    plan_clear();
    for (int n = 20; n < MAXN; n++) done_v[n] = 1'b1;
    err_v[300] = 1'b1;
    run_scenario("drain_err", 305);

    // dump_end and watchdog expiry on the same edge -> dump_end wins
    plan_clear();
    maxInterval = 32'd100; dumpEnd = 64'd105;
    run_scenario("dump_vs_wdog", 110);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      plan_clear();
      m = $urandom_range(10, 60);
      maxInterval = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'(m);
      stop_at = $urandom_range(10, 350);
      k = RESET_CYCLES;
      while (k < stop_at) begin
        k += $urandom_range(1, m);
        if (k < MAXN) commit_v[k] = 1'b1;
      end
      dumpStart = 64'($urandom_range(0, 40));
      dumpEnd = ($urandom_range(0, 1) == 0) ? '0 : 64'($urandom_range(50, 400));
      if ($urandom_range(0, 1) == 1) err_v[$urandom_range(3, 600)] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(6, 400);
        for (int n = k; n < MAXN; n++) done_v[n] = 1'b1;
        k += $urandom_range(0, 30);
        for (int n = k; n < MAXN; n++) idle_v[n] = 1'b1;
      end
      predict();
      edges = (fin_n < 1500) ? fin_n + 3 : 1500;
      run_scenario($sformatf("rand%0d", r), edges);
    end

    // final reset out of a terminal state, checked with no clock edge
    resetN = 1'b0;
    #2;
    check_reset("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
